mem_io_responder: RTL



---
 rtl/mem_io_pkg.sv | 29 ++
 rtl/io_tx_fifo.sv | 75 +++++++
 rtl/mem_io_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared definitions for the byte-wide memory/IO responder.
// Holds the IO-space decode constants, the status register bit map and the
// access-kind decode used by the top level.
package mem_io_pkg;

  // addr[17:16] value that selects IO space instead of RAM
  localparam logic [1:0] IO_BASE_SEL   = 2'b11;

  // IO register offsets (addr[2:0])
  localparam logic [2:0] TX_OFFSET     = 3'h0;
  localparam logic [2:0] STATUS_OFFSET = 3'h4;

  // Status register bit positions
  localparam int STAT_FULL     = 0;
  localparam int STAT_RX_VALID = 1;

  typedef enum logic [1:0] {
    ACC_RAM_RD,
    ACC_RAM_WR,
    ACC_IO_RD,
    ACC_IO_WR
  } access_e;

  function automatic access_e decode_access(input logic wr, input logic [1:0] sel);
    if (sel == IO_BASE_SEL) return wr ? ACC_IO_WR : ACC_IO_RD;
    return wr ? ACC_RAM_WR : ACC_RAM_RD;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous TX FIFO with occupancy count and registered almost-full flag.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            global enable; when 0 nothing moves
//   push, din     write request and data (dropped when full and not popping)
//   pop           read request (ignored when empty)
//   dout, valid   head entry (0 when empty) and non-empty flag
//   almost_full   registered (count_next >= DEPTH-1)
//   count         current occupancy
//   ovf           sticky flag: a push was dropped
module io_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = en && pop && (count != '0);
  // A full FIFO still accepts a push when it pops in the same cycle.
  assign do_push = en && push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    // NOTE: default first so every path assigns count_next; no latch is inferred.
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      almost_full <= (count_next >= CNT_W'(DEPTH - 1));
      if (en && push && !do_push) ovf <= 1'b1;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by count, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign valid = (count != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory and IO responder for the CPU-side memory controller.
// RAM of 2**ADDR_W bytes with 1-cycle registered read; addr[17:16]==2'b11
// selects IO space: TX register at offset 0 (write), RX data at offset 0
// (read), status at offset 4 (read). IO writes drain through a TX FIFO.
// Ports:
//   clk_in, rst_n_in     clock, asynchronous active-low reset
//   rdy_in               global enable
//   mem_a, mem_dout, mem_wr   address, write byte, write strobe
//   mem_din              registered read byte
//   io_buffer_full       TX FIFO back-pressure
//   tx_data, tx_valid, tx_ready   host-side drain port
//   rx_data, rx_valid    host input byte
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    ADDR_W     = 17,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = "ram.hex"
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        rst_sync;
  logic              rst_n;
  access_e           acc;
  logic [ADDR_W-1:0] ram_idx;
  logic [7:0]        io_rd;
  logic [7:0]        ram [2**ADDR_W];
  logic [CNT_W-1:0]  fifo_count;
  logic              ovf;
  logic              unused_dbg;

  // Assertion is immediate; release is delayed two clk_in edges.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign acc     = decode_access(mem_wr, mem_a[17:16]);
  assign ram_idx = mem_a[ADDR_W-1:0];

  always_comb begin
    io_rd = '0;
    case (mem_a[2:0])
      TX_OFFSET:     io_rd = rx_valid ? rx_data : 8'h00;
      STATUS_OFFSET: begin
        io_rd[STAT_FULL]     = io_buffer_full;
        io_rd[STAT_RX_VALID] = rx_valid;
      end
      default:       io_rd = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && acc == ACC_RAM_WR) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mem_din <= 8'h00;
    end else if (rdy_in) begin
      case (acc)
        ACC_RAM_RD: mem_din <= ram[ram_idx];
        ACC_IO_RD:  mem_din <= io_rd;
        default:    mem_din <= 8'h00;
      endcase
    end
  end

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk         (clk_in),
    .rst_n       (rst_n),
    .en          (rdy_in),
    .push        (acc == ACC_IO_WR && mem_a[2:0] == TX_OFFSET),
    .din         (mem_dout),
    .pop         (tx_ready),
    .dout        (tx_data),
    .valid       (tx_valid),
    .almost_full (io_buffer_full),
    .count       (fifo_count),
    .ovf         (ovf)
  );

  // Debug-only state and upper address bits that alias away.
  assign unused_dbg = ^{mem_a, fifo_count, ovf};

endmodule
